// File: rtl/input_debouncer_if.sv
// rtl/input_debouncer_if.sv - button input and debounced level/strobe bundle
interface input_debouncer_if;
    logic btn_in;
    logic x1;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    modport master (
        output btn_in,
        input  x1,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    modport slave (
        input  btn_in,
        output x1,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
endinterface

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronizing four-state debouncer with edge strobes
module input_debouncer #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input_debouncer_if.slave bus
);
    typedef enum logic [1:0] {
        LOW      = 2'b00,
        RISE_CHK = 2'b01,
        HIGH     = 2'b10,
        FALL_CHK = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_x1;
    logic             r_rise;
    logic             r_fall;
    logic             w_s;

    // btn_in is asynchronous; only the second flop is trusted downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_x1    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LOW: begin
                    r_x1 <= 1'b0;
                    if (w_s) begin
                        r_state <= RISE_CHK;
                        r_cnt   <= '0;
                    end
                end
                RISE_CHK: begin
                    if (!w_s) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                        r_x1    <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    r_x1 <= 1'b1;
                    if (!w_s) begin
                        r_state <= FALL_CHK;
                        r_cnt   <= '0;
                    end
                end
                FALL_CHK: begin
                    if (w_s) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        r_x1    <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                    r_x1    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x1         = r_x1;
    assign bus.rise_pulse = r_rise;
    assign bus.fall_pulse = r_fall;
    assign bus.busy       = (r_state == RISE_CHK) || (r_state == FALL_CHK);
endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer
module tb_input_debouncer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_rise;
    int   n_fall;
    int   n_busy;

    input_debouncer_if bus ();

    input_debouncer #(.DEB_CYCLES(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one rising edge, sample 1ns later, tally strobes
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.rise_pulse === 1'b1) n_rise++;
        if (bus.fall_pulse === 1'b1) n_fall++;
        if (bus.busy === 1'b1)       n_busy++;
        chk("pulse_exclusive", bus.rise_pulse & bus.fall_pulse, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_rise = 0;
        n_fall = 0;
        n_busy = 0;
        reset      = 1'b1;
        bus.btn_in = 1'b0;
        #3;
        chk("reset_x1",   bus.x1,         1'b0);
        chk("reset_rise", bus.rise_pulse, 1'b0);
        chk("reset_fall", bus.fall_pulse, 1'b0);
        chk("reset_busy", bus.busy,       1'b0);
        tick();
        tick();
        reset = 1'b0;

        // idle low for 100 cycles
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_x1",   bus.x1,         1'b0);
            chk("idle_rise", bus.rise_pulse, 1'b0);
            chk("idle_fall", bus.fall_pulse, 1'b0);
            chk("idle_busy", bus.busy,       1'b0);
        end

        // clean rise: busy after E2..E17, x1/rise after E18
        bus.btn_in = 1'b1;
        tick();
        tick();
        chk("rise_e1_busy", bus.busy, 1'b0);
        for (int e = 2; e <= 17; e++) begin
            tick();
            chk("rise_busy", bus.busy, 1'b1);
            chk("rise_x1_hold", bus.x1, 1'b0);
        end
        tick();
        chk("rise_e18_x1",   bus.x1,         1'b1);
        chk("rise_e18_rp",   bus.rise_pulse, 1'b1);
        chk("rise_e18_busy", bus.busy,       1'b0);
        tick();
        chk("rise_e19_rp", bus.rise_pulse, 1'b0);
        chk("rise_e19_x1", bus.x1,         1'b1);
        for (int i = 20; i < 40; i++) tick();
        chk("rise_hold_x1", bus.x1, 1'b1);

        // clean fall
        bus.btn_in = 1'b0;
        for (int e = 0; e <= 17; e++) begin
            tick();
            chk("fall_x1_hold", bus.x1, 1'b1);
        end
        tick();
        chk("fall_e18_x1", bus.x1,         1'b0);
        chk("fall_e18_fp", bus.fall_pulse, 1'b1);
        chk("fall_e18_rp", bus.rise_pulse, 1'b0);
        tick();
        chk("fall_e19_fp", bus.fall_pulse, 1'b0);
        for (int i = 0; i < 5; i++) tick();

        // bounce: 5 high, 3 low, then steady high
        n_rise = 0;
        bus.btn_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bounce_x1_a", bus.x1, 1'b0);
        end
        bus.btn_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bounce_x1_b", bus.x1, 1'b0);
        end
        bus.btn_in = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            tick();
            chk("bounce_x1_c", bus.x1, 1'b0);
        end
        tick();
        chk("bounce_e18_x1", bus.x1,         1'b1);
        chk("bounce_e18_rp", bus.rise_pulse, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk_int("bounce_rise_count", n_rise, 1);

        // return to LOW
        bus.btn_in = 1'b0;
        for (int i = 0; i < 22; i++) tick();
        chk("relow_x1",   bus.x1,   1'b0);
        chk("relow_busy", bus.busy, 1'b0);

        // single-cycle glitch
        n_rise = 0;
        n_fall = 0;
        n_busy = 0;
        bus.btn_in = 1'b1;
        tick();
        bus.btn_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch_x1", bus.x1, 1'b0);
        end
        chk_int("glitch_busy_cycles", n_busy, 1);
        chk_int("glitch_rise_count",  n_rise, 0);
        chk_int("glitch_fall_count",  n_fall, 0);

        // reset during RISE_CHK with cnt=7
        bus.btn_in = 1'b1;
        for (int e = 0; e <= 9; e++) tick();
        chk("midq_busy_before", bus.busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midq_reset_busy", bus.busy,       1'b0);
        chk("midq_reset_x1",   bus.x1,         1'b0);
        chk("midq_reset_rp",   bus.rise_pulse, 1'b0);
        tick();
        tick();
        reset  = 1'b0;
        n_rise = 0;
        for (int e = 0; e <= 17; e++) begin
            tick();
            chk("post_reset_x1_hold", bus.x1, 1'b0);
        end
        tick();
        chk("post_reset_e18_x1", bus.x1,         1'b1);
        chk("post_reset_e18_rp", bus.rise_pulse, 1'b1);
        tick();
        tick();
        chk_int("post_reset_rise_count", n_rise, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 16: the number of consecutive stable synchronized samples required to accept a level change.
REQ-002 The block SHALL have parameter CNT_W, default 5: the stability counter width; legal range is 2 <= DEB_CYCLES <= 2**CNT_W.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port btn_in  input  1  raw, bouncing, asynchronous input.
REQ-006 Port x1  output  1  debounced level, registered; feeds the downstream sequence FSM input.
REQ-007 Port rise_pulse  output  1  one-cycle strobe on accepted 0->1, registered.
REQ-008 Port fall_pulse  output  1  one-cycle strobe on accepted 1->0, registered.
REQ-009 Port busy  output  1  high while a level change is under qualification; decoded from the state register only.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer; the second flop output is the sample s; no other logic SHALL read btn_in.
REQ-011 The state machine SHALL have exactly 4 states: LOW, RISE_CHK, HIGH, FALL_CHK.
REQ-012 LOW: x1=0; on s=1 -> RISE_CHK with cnt<=0; else remain.
REQ-013 RISE_CHK: on s=0 -> LOW, no pulse (bounce rejected); on s=1 with cnt<DEB_CYCLES-1 -> cnt<=cnt+1; on s=1 with cnt==DEB_CYCLES-1 -> HIGH, x1<=1, rise_pulse<=1.
REQ-014 HIGH: x1=1; on s=0 -> FALL_CHK with cnt<=0; else remain.
REQ-015 FALL_CHK: on s=1 -> HIGH, no pulse; on s=0 with cnt<DEB_CYCLES-1 -> cnt<=cnt+1; on s=0 with cnt==DEB_CYCLES-1 -> LOW, x1<=0, fall_pulse<=1.
REQ-016 Latency: btn_in changes before edge E0 and holds; x1 SHALL change immediately after edge E0+DEB_CYCLES+2.
REQ-017 rise_pulse/fall_pulse SHALL be high for exactly one cycle, coincident with the first cycle of the new x1 level; both SHALL never be high together.
REQ-018 busy SHALL be 1 exactly in RISE_CHK or FALL_CHK.
REQ-019 Any unused/illegal state encoding SHALL return to LOW on the next edge with x1=0 and pulses 0.
REQ-020 cnt SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.

Reset
REQ-021 Asserted reset SHALL immediately force state=LOW, cnt=0, both sync flops=0, x1=0, rise_pulse=0, fall_pulse=0 and busy=0, regardless of clk.
REQ-022 Reset asserted mid-qualification SHALL abandon the check with no pulse.
REQ-023 If btn_in=1 at reset release, the block SHALL perform a normal rise qualification and emit rise_pulse.

Verification
REQ-024 Reset, btn_in=0 for 100 cycles -> x1=0, rise_pulse=0, fall_pulse=0, busy=0 throughout.
REQ-025 DEB_CYCLES=16, btn_in 0->1 before E0, held 40 cycles -> busy=1 after E2 through E17; x1=1 and rise_pulse=1 after E18; rise_pulse=0 after E19.
REQ-026 From HIGH, btn_in 1->0 before E0, held -> x1=0 and fall_pulse high for one cycle after E18.
REQ-027 Bounce: btn_in high 5 cycles, low 3 cycles, then high steady -> no x1 change until 18 edges after the final rise; exactly one rise_pulse.
REQ-028 Single-cycle glitch high on btn_in while in LOW -> x1 stays 0, no pulse, busy high for 1 cycle only.
REQ-029 Reset asserted in RISE_CHK (cnt=7), btn_in held 1 -> x1=0, busy=0 immediately; after release, x1=1 after edge 18 counted from the first edge after deassertion; one rise_pulse.
